spi_frame_tx: RTL and testbench

//   Downstream consumer of the UART receiver: takes received bytes over the rx_ready/rx_ack

---
 rtl/spi_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_spi_frame_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// Length-prefixed frame to SPI mode-0 master (MSB first); MISO bytes returned per payload byte.
// Latency: first SCK rise CLK_DIV cycles after CS falls; 16*CLK_DIV cycles per byte on the wire.
// Backpressure: bytes are taken only when the FSM can use them; rx_ready may stay high indefinitely.
module spi_frame_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_ack,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic [7:0] miso_data,
    output logic       miso_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK_LEN   = 3'd1,
        WAIT_BYTE = 3'd2,
        CS_SETUP  = 3'd3,
        SHIFT     = 3'd4,
        CS_HOLD   = 3'd5
    } state_t;

    // Phase counter needs at least one bit even when CLK_DIV is 1.
    localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    state_t        state;
    logic [7:0]    remaining;
    logic [7:0]    shreg;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic          accept;
    logic          phase_done;

    // The receiver only drops rx_ready one edge after seeing rx_ack, so the
    // ack cycle must never count as a fresh byte.
    assign accept     = rx_ready && !rx_ack;
    assign phase_done = (phase == PH_LAST);

    // Frame FSM, SCK/CS/MOSI generation and MISO capture, all outputs registered.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state      <= IDLE;
            remaining  <= 8'd0;
            shreg      <= 8'd0;
            phase      <= '0;
            bit_cnt    <= 3'd0;
            rx_ack     <= 1'b0;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= 1'b1;
            miso_data  <= 8'd0;
            miso_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_ack     <= 1'b0;
            miso_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Any byte seen here is a length byte.
                    if (accept) begin
                        remaining <= rx_data;
                        rx_ack    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACK_LEN;
                    end
                end

                ACK_LEN: begin
                    // Empty frames are dropped without touching the SPI bus.
                    if (remaining == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT_BYTE;
                    end
                end

                WAIT_BYTE: begin
                    // CS stays asserted across slow payload arrival; SCK parked low.
                    spi_sck <= 1'b0;
                    if (accept) begin
                        shreg    <= rx_data;
                        spi_mosi <= rx_data[7];
                        rx_ack   <= 1'b1;
                        phase    <= '0;
                        if (spi_cs_n) begin
                            spi_cs_n <= 1'b0;
                            state    <= CS_SETUP;
                        end else begin
                            state    <= SHIFT;
                        end
                    end
                end

                CS_SETUP: begin
                    // The setup interval doubles as the first bit's low phase,
                    // so it ends with the first SCK rise and MISO sample.
                    if (phase_done) begin
                        phase   <= '0;
                        spi_sck <= 1'b1;
                        shreg   <= {shreg[6:0], spi_miso};
                        state   <= SHIFT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                SHIFT: begin
                    if (phase_done) begin
                        phase <= '0;
                        if (!spi_sck) begin
                            // Rising edge: sample MISO, shift toward MSB.
                            spi_sck <= 1'b1;
                            shreg   <= {shreg[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                // Byte complete: shreg now holds all 8 captured bits.
                                bit_cnt    <= 3'd0;
                                miso_data  <= shreg;
                                miso_valid <= 1'b1;
                                remaining  <= remaining - 8'd1;
                                state      <= (remaining == 8'd1) ? CS_HOLD : WAIT_BYTE;
                            end else begin
                                // Falling edge: after the shift, bit 7 is the next MOSI bit.
                                bit_cnt  <= bit_cnt + 3'd1;
                                spi_mosi <= shreg[7];
                            end
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                CS_HOLD: begin
                    // Keep CS low for one half-period after the final SCK fall.
                    if (phase_done) begin
                        phase    <= '0;
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                default: begin
                    spi_sck  <= 1'b0;
                    spi_cs_n <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
module tb_spi_frame_tx;

    localparam int CLK_DIV = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;
    logic [7:0] miso_data;
    logic       miso_valid;
    logic       busy;

    spi_frame_tx #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_ack    (rx_ack),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n),
        .miso_data (miso_data),
        .miso_valid(miso_valid),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // ---------------- bus monitor (samples on falling sys_clk) ----------------
    int         cyc = 0;
    int         acks = 0, cs_falls = 0, cs_rises = 0, bad_edges = 0, busy_cyc = 0;
    int         rise_cnt = 0;
    int         cs_fall_cyc = 0, first_rise_cyc = 0, last_fall_cyc = 0, cs_rise_cyc = 0;
    logic       need_first = 1'b0;
    logic       prev_sck = 1'b0, prev_cs = 1'b1;
    bit         mosi_q[$];
    logic [7:0] miso_q[$];

    always @(negedge sys_clk) begin
        cyc      <= cyc + 1;
        prev_sck <= spi_sck;
        prev_cs  <= spi_cs_n;
        if (rx_ack === 1'b1) acks <= acks + 1;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
        if (miso_valid === 1'b1) miso_q.push_back(miso_data);
        if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
            cs_falls    <= cs_falls + 1;
            cs_fall_cyc <= cyc;
            need_first  <= 1'b1;
        end
        if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
            cs_rises    <= cs_rises + 1;
            cs_rise_cyc <= cyc;
        end
        if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
            rise_cnt <= rise_cnt + 1;
            mosi_q.push_back(spi_mosi);
            if (need_first) begin
                first_rise_cyc <= cyc;
                need_first     <= 1'b0;
            end
        end
        if (spi_sck === 1'b0 && prev_sck === 1'b1) last_fall_cyc <= cyc;
        if (spi_sck !== prev_sck && spi_cs_n !== 1'b0) bad_edges <= bad_edges + 1;
    end

    // ---------------- SPI slave: byte array shifted out MSB first ----------------
    logic       loop_en;
    int         rise_base;
    logic [7:0] slave_arr [256];
    logic       slave_bit;
    int         rel;

    always_comb begin
        rel       = rise_cnt - rise_base;
        slave_bit = slave_arr[(rel >> 3) & 255][7 - (rel & 7)];
    end

    assign spi_miso = loop_en ? spi_mosi : slave_bit;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    int s_ack, s_val, s_mosi, s_csf, s_csr, s_bad, s_busy;

    task automatic snap();
        s_ack     = acks;
        s_val     = miso_q.size();
        s_mosi    = mosi_q.size();
        s_csf     = cs_falls;
        s_csr     = cs_rises;
        s_bad     = bad_edges;
        s_busy    = busy_cyc;
        rise_base = rise_cnt;
    endtask

    // Receiver model: present byte, wait for ack, drop rx_ready one edge later.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge sys_clk);
        @(negedge sys_clk);
        rx_data  = b;
        rx_ready = 1'b1;
        n = 0;
        while (rx_ack !== 1'b1 && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack byte=%0h", b);
        end
        @(posedge sys_clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic run_frame(input int len, input logic [7:0] pay [8], input int gap_max);
        send_byte(8'(len), $urandom_range(0, gap_max));
        for (int i = 0; i < len; i++) send_byte(pay[i], $urandom_range(0, gap_max));
        wait_idle();
    endtask

    // Reference: MOSI carries payload MSB first, one MISO byte per payload byte,
    // L+1 acks, one CS assertion for a non-empty frame, no SCK edge with CS high.
    task automatic verify(input string tag, input int len, input logic [7:0] pay [8],
                          input logic [7:0] exp_miso [8]);
        logic [7:0] got;
        chk({tag, "_acks"}, 32'(acks - s_ack), 32'(len + 1));
        chk({tag, "_valids"}, 32'(miso_q.size() - s_val), 32'(len));
        chk({tag, "_cs_falls"}, 32'(cs_falls - s_csf), 32'(len > 0));
        chk({tag, "_cs_rises"}, 32'(cs_rises - s_csr), 32'(len > 0));
        chk({tag, "_bad_edges"}, 32'(bad_edges - s_bad), 32'd0);
        chk({tag, "_rises"}, 32'(mosi_q.size() - s_mosi), 32'(8 * len));
        if (len == 0)
            chk({tag, "_len0_busy_1to2"},
                32'((busy_cyc - s_busy) >= 1 && (busy_cyc - s_busy) <= 2), 32'd1);
        for (int i = 0; i < len; i++) begin
            if (mosi_q.size() >= s_mosi + 8 * (i + 1)) begin
                got = 8'd0;
                for (int k = 0; k < 8; k++) got = {got[6:0], 1'(mosi_q[s_mosi + 8 * i + k])};
                chk({tag, "_mosi_byte"}, 32'(got), 32'(pay[i]));
            end
            if (miso_q.size() > s_val + i)
                chk({tag, "_miso_byte"}, 32'(miso_q[s_val + i]), 32'(exp_miso[i]));
        end
    endtask

    typedef struct {
        int          len;
        logic [23:0] pay;
        logic [7:0]  sl;
        int          exp_acks;
        int          exp_valid;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] pay  [8];
    logic [7:0] expm [8];
    int         n;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{len: 0, pay: 24'h000000, sl: 8'h00, exp_acks: 1, exp_valid: 0, exp_last: 8'h00};
        vecs[1] = '{len: 1, pay: 24'hA50000, sl: 8'h5A, exp_acks: 2, exp_valid: 1, exp_last: 8'h5A};
        vecs[2] = '{len: 2, pay: 24'h817E00, sl: 8'hC3, exp_acks: 3, exp_valid: 2, exp_last: 8'hC3};
        vecs[3] = '{len: 3, pay: 24'h00FF55, sl: 8'h96, exp_acks: 4, exp_valid: 3, exp_last: 8'h96};

        sys_rst   = 1'b0;
        rx_ready  = 1'b1;
        rx_data   = 8'h00;
        loop_en   = 1'b0;
        rise_base = 0;
        for (int i = 0; i < 256; i++) slave_arr[i] = 8'h00;

        // Reset held with rx_ready high: nothing accepted, bus idle.
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            chk("rst_ack", 32'(rx_ack), 32'd0);
            chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
            chk("rst_sck", 32'(spi_sck), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_miso_data", 32'(miso_data), 32'd0);
        chk("rst_miso_valid", 32'(miso_valid), 32'd0);
        snap();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rel_ack", 32'(rx_ack), 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        @(posedge sys_clk);
        #1 rx_ready = 1'b0;
        chk("rel_ack_once", 32'(rx_ack), 32'd0);
        repeat (4) @(negedge sys_clk);
        chk("rel_ack_count", 32'(acks - s_ack), 32'd1);
        chk("rel_cs_n", 32'(spi_cs_n), 32'd1);

        // Table-driven frames (fixed slave byte per frame).
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) begin
                pay[i]  = (i < 3) ? vecs[v].pay[23 - 8 * i -: 8] : 8'h00;
                expm[i] = vecs[v].sl;
            end
            for (int i = 0; i < 256; i++) slave_arr[i] = vecs[v].sl;
            snap();
            run_frame(vecs[v].len, pay, 1);
            verify($sformatf("vec%0d", v), vecs[v].len, pay, expm);
            chk($sformatf("vec%0d_tbl_acks", v), 32'(acks - s_ack), 32'(vecs[v].exp_acks));
            chk($sformatf("vec%0d_tbl_valid", v), 32'(miso_q.size() - s_val), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid > 0)
                chk($sformatf("vec%0d_tbl_last", v), 32'(miso_data), 32'(vecs[v].exp_last));
        end

        // {01,A5} looped back: CS setup and hold timing.
        loop_en = 1'b1;
        pay[0] = 8'hA5;
        expm[0] = 8'hA5;
        snap();
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        wait_idle();
        verify("a5", 1, pay, expm);
        chk("a5_cs_setup", 32'(first_rise_cyc - cs_fall_cyc), 32'(CLK_DIV));
        chk("a5_cs_hold", 32'(cs_rise_cyc - last_fall_cyc), 32'(CLK_DIV));
        chk("a5_miso_data", 32'(miso_data), 32'hA5);

        // {03,11,22,33} with a 50-cycle stall before 0x22: CS held, SCK parked.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        expm = pay;
        snap();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        repeat (45) @(negedge sys_clk);
        chk("gap_sck", 32'(spi_sck), 32'd0);
        chk("gap_cs_n", 32'(spi_cs_n), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        send_byte(8'h22, 5);
        send_byte(8'h33, 0);
        wait_idle();
        verify("gap", 3, pay, expm);

        // Reset in the middle of a byte, then a clean frame.
        pay[0] = 8'hF0;
        snap();
        send_byte(8'h01, 0);
        send_byte(8'hF0, 0);
        n = 0;
        while (mosi_q.size() - s_mosi < 4 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        chk("midrst_reached_bit4", 32'(n < 500), 32'd1);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("midrst_sck", 32'(spi_sck), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        pay[0] = 8'h3C;
        expm[0] = 8'h3C;
        snap();
        send_byte(8'h01, 0);
        send_byte(8'h3C, 0);
        wait_idle();
        verify("post_rst", 1, pay, expm);

        // Randomized frames against the slave array.
        loop_en = 1'b0;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) begin
                pay[i]       = 8'($urandom);
                expm[i]      = 8'($urandom);
                slave_arr[i] = expm[i];
            end
            snap();
            run_frame(len, pay, 3);
            verify($sformatf("rnd%0d", f), len, pay, expm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
